slave_port: RTL and testbench
=============================

# slave_port

Bus-side serial endpoint for a memory-mapped slave, the downstream counterpart of the master port on the serial system bus. It receives a 16-bit address (MSB first), a mode bit and, for writes, 8 serial data bits from the bus, then performs one parallel access on a local memory interface. For reads it returns 8 serial data bits (MSB first). It raises `split` to the arbiter when a read stalls, so the bus can be released while the memory completes the access.

## Interface
- `ADDR_W`, 12: number of low address bits forwarded to memory (1..16).
- `SPLIT_EN`, 1: 1 enables split signalling; 0 holds `split` low permanently.
- `SPLIT_CYCLES`, 8: number of RD_WAIT cycles without `mem_rd_valid` before `split` asserts (≥1).
- `clk`  in  1  clock; all logic is rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `select`  in  1  decoder select; high while this slave is the transaction target.
- `mode`  in  1  transfer direction from the master; 1 = write, 0 = read.
- `wr_bus`  in  1  serial address/write data from the master.
- `master_valid`  in  1  master presents a valid bit on `wr_bus`.
- `slave_ready`  out  1  slave accepts a bit this cycle.
- `rd_bus`  out  1  serial read data to the master.
- `slave_valid`  out  1  slave presents a valid bit on `rd_bus`.
- `master_ready`  in  1  master accepts a bit on `rd_bus`.
- `split`  out  1  split request to the arbiter.
- `mem_addr`  out  ADDR_W  access address: the low ADDR_W bits of the received address.
- `mem_wr_data`  out  8  write data.
- `mem_wr_en`  out  1  single-cycle write strobe.
- `mem_rd_en`  out  1  single-cycle read strobe.
- `mem_rd_data`  in  8  read data; valid when `mem_rd_valid` is high.
- `mem_rd_valid`  in  1  read data valid pulse.

## Operation
- States:
  - IDLE: waiting for the first address bit.
  - ADDR: receiving the remaining address bits.
  - WDATA: receiving 8 write data bits.
  - WRITE: issuing the memory write.
  - RD_REQ: issuing the memory read.
  - RD_WAIT: waiting for read data.
  - RDATA: sending 8 read data bits.
- Inbound handshake: a bit transfers on a rising edge where `master_valid & slave_ready` is high. The received bit is shifted into the LSB of a 16-bit address register (or 8-bit data register in WDATA).
- `slave_ready = select & (state ∈ {IDLE, ADDR, WDATA})`.
- IDLE → ADDR on the first inbound handshake; the bit counter becomes 1.
- ADDR: the counter increments per handshake. The handshake with counter == 15 completes the address and samples `mode`. The next state is WDATA if `mode` = 1, otherwise RD_REQ. The counter clears.
- WDATA: the handshake with counter == 7 completes the data byte; next state is WRITE.
- WRITE: `mem_wr_en` = 1 for exactly one cycle, with `mem_addr` and `mem_wr_data` stable. Next state is IDLE.
- RD_REQ: `mem_rd_en` = 1 for one cycle. Next state is RD_WAIT and the wait counter clears.
- RD_WAIT:
  - `mem_rd_valid` is sampled only in this state; a pulse in any other state is ignored.
  - When `mem_rd_valid` is seen, `mem_rd_data` is loaded into the read shift register and the FSM moves to RDATA.
  - Otherwise the wait counter increments, saturating at SPLIT_CYCLES.
- `split`:
  - Registered; set when SPLIT_EN = 1, state = RD_WAIT, wait counter == SPLIT_CYCLES-1 and `mem_rd_valid` = 0.
  - Cleared on the edge that captures read data.
- RDATA:
  - `slave_valid` = 1 and `rd_bus` = shift register MSB.
  - Each `slave_valid & master_ready` edge shifts the register left and increments the counter.
  - The handshake with counter == 7 returns the FSM to IDLE.
  - `select` is ignored, so a split master can reconnect.
- Abort: `select` = 0 while in ADDR or WDATA returns the FSM to IDLE next cycle and clears the counter. No memory strobe is issued.
- `mem_addr` = address register[ADDR_W-1:0]. It is held stable from the end of ADDR until the FSM re-enters IDLE.

## Timing
- Reset (async assert, synchronous release):
  - State = IDLE; all counters and shift registers = 0.
  - Outputs `slave_ready`, `slave_valid`, `rd_bus`, `split`, `mem_wr_en` and `mem_rd_en` = 0; `mem_addr` and `mem_wr_data` = 0.
- Reset mid-transaction drops everything with no memory strobe.
- Write latency: `mem_wr_en` is high in the cycle after the 8th data handshake.
- Read: `mem_rd_en` is high the cycle after the 16th address handshake. RDATA is entered the cycle after `mem_rd_valid`, and `slave_valid` is high that same cycle.
- Minimum transaction length with no stalls: 16+8+1 cycles for a write; 16+1+1+8 for a read with memory latency 1.
- `slave_valid` never asserts in the same cycle as `slave_ready`.
- `mem_wr_en` and `mem_rd_en` are mutually exclusive and never high two consecutive cycles.

## Test plan
- Write 0xA5 to address 0x1234 with continuous handshakes → `mem_wr_en` pulses once, `mem_addr` = 0x234, `mem_wr_data` = 0xA5; FSM back in IDLE the following cycle.
- Read 0x0C1 with memory latency 2 returning 0x3C → `mem_rd_en` pulses once; `rd_bus` serializes 0,0,1,1,1,1,0,0; `split` stays 0.
- Read with latency 20, SPLIT_CYCLES = 8 → `split` rises after 8 RD_WAIT cycles and clears on the capture edge. `master_ready` held low for 5 cycles in RDATA leaves `rd_bus` unchanged; data then completes correctly.
- `select` dropped after 7 address bits → FSM returns to IDLE with no memory strobe. A following write of 0xFF to address 0x0001 completes normally.
- `master_valid` toggling every other cycle during a write of 0x5A → only handshake cycles shift; result `mem_wr_data` = 0x5A.
- `rstn` asserted during RD_WAIT with `split` = 1 → `split` and all outputs go to 0 immediately. A later `mem_rd_valid` pulse is ignored.

Source files
------------

// File: rtl/slave_port.sv
// Serial bus slave endpoint: 16-bit address + mode (+8 write bits) in, one parallel memory access, 8 read bits out.
// Write strobe 1 cycle after last data bit, read strobe 1 cycle after last address bit; stalls on master_valid/master_ready, split on slow reads.
module slave_port #(
    parameter int ADDR_W       = 12,
    parameter bit SPLIT_EN     = 1'b1,
    parameter int SPLIT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              select,
    input  logic              mode,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    output logic              rd_bus,
    output logic              slave_valid,
    input  logic              master_ready,
    output logic              split,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    input  logic              mem_rd_valid
);

    localparam int WCNT_W = $clog2(SPLIT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(SPLIT_CYCLES);
    localparam logic [WCNT_W-1:0] WAIT_SET = WCNT_W'(SPLIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WRITE, RD_REQ, RD_WAIT, RDATA
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         bit_cnt;
    logic [ADDR_W-1:0]  addr_sr;
    logic [7:0]         wdata_sr;
    logic [7:0]         rdata_sr;
    logic [WCNT_W-1:0]  wait_cnt;
    logic               split_q;
    logic               in_hs;
    logic               out_hs;

    assign in_hs  = master_valid & slave_ready;
    assign out_hs = slave_valid & master_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_hs) state_nxt = ADDR;
            ADDR: begin
                if (!select)                          state_nxt = IDLE;
                else if (in_hs && bit_cnt == 4'd15)   state_nxt = mode ? WDATA : RD_REQ;
            end
            WDATA: begin
                if (!select)                          state_nxt = IDLE;
                else if (in_hs && bit_cnt == 4'd7)    state_nxt = WRITE;
            end
            WRITE:   state_nxt = IDLE;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (mem_rd_valid) state_nxt = RDATA;
            RDATA:   if (out_hs && bit_cnt == 4'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        case (state)
            IDLE, ADDR, WDATA: slave_ready = select;
            WRITE:             mem_wr_en   = 1'b1;
            RD_REQ:            mem_rd_en   = 1'b1;
            RDATA:             slave_valid = 1'b1;
            default: ;
        endcase
        rd_bus = slave_valid & rdata_sr[7];
    end

    // Only the low ADDR_W address bits are kept: after 16 shifts they hold exactly the bits memory needs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            addr_sr  <= '0;
            wdata_sr <= '0;
            rdata_sr <= '0;
            wait_cnt <= '0;
            split_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        addr_sr <= (addr_sr << 1) | ADDR_W'(wr_bus);
                        bit_cnt <= 4'd1;
                    end
                end
                ADDR: begin
                    if (!select) begin
                        bit_cnt <= '0;
                    end else if (in_hs) begin
                        addr_sr <= (addr_sr << 1) | ADDR_W'(wr_bus);
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                WDATA: begin
                    if (!select) begin
                        bit_cnt <= '0;
                    end else if (in_hs) begin
                        wdata_sr <= {wdata_sr[6:0], wr_bus};
                        bit_cnt  <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                RD_REQ: wait_cnt <= '0;
                RD_WAIT: begin
                    if (mem_rd_valid) begin
                        rdata_sr <= mem_rd_data;
                        split_q  <= 1'b0;
                    end else begin
                        if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + WCNT_W'(1);
                        if (SPLIT_EN && wait_cnt == WAIT_SET) split_q <= 1'b1;
                    end
                end
                RDATA: begin
                    if (out_hs) begin
                        rdata_sr <= {rdata_sr[6:0], 1'b0};
                        bit_cnt  <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign split       = split_q;
    assign mem_addr    = addr_sr;
    assign mem_wr_data = wdata_sr;

endmodule

// File: tb/tb_slave_port.sv
// Randomized bench for slave_port: a byte-array memory plus a queue of expected writes act as the reference.
module tb_slave_port;

    localparam int ADDR_W       = 12;
    localparam int SPLIT_CYCLES = 8;

    logic              clk          = 1'b0;
    logic              rstn         = 1'b0;
    logic              select       = 1'b0;
    logic              mode         = 1'b0;
    logic              wr_bus       = 1'b0;
    logic              master_valid = 1'b0;
    logic              master_ready = 1'b0;
    logic              mem_rd_valid = 1'b0;
    logic [7:0]        mem_rd_data  = 8'h00;
    logic              slave_ready;
    logic              rd_bus;
    logic              slave_valid;
    logic              split;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wr_data;
    logic              mem_wr_en;
    logic              mem_rd_en;

    slave_port #(.ADDR_W(ADDR_W), .SPLIT_EN(1'b1), .SPLIT_CYCLES(SPLIT_CYCLES)) dut (
        .clk(clk), .rstn(rstn), .select(select), .mode(mode), .wr_bus(wr_bus),
        .master_valid(master_valid), .slave_ready(slave_ready), .rd_bus(rd_bus),
        .slave_valid(slave_valid), .master_ready(master_ready), .split(split),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    int         n_checks    = 0;
    int         n_errors    = 0;
    int         rd_expected = 0;
    int         rd_seen     = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] mem_model [0:(1<<ADDR_W)-1];
    wr_t        wr_q [$];
    wr_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Invariants and write scoreboard, sampled on the falling edge.
    always begin
        @(negedge clk);
        if (rstn) begin
            check("vld_and_rdy", 32'(slave_valid & slave_ready), 0);
            check("strobe_excl", 32'(mem_wr_en & mem_rd_en), 0);
            check("strobe_b2b", 32'((mem_wr_en | mem_rd_en) & prev_strobe), 0);
            if (mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_wr_en), 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    check("sb_wr_addr", 32'(mem_addr), 32'(mon_e.a));
                    check("sb_wr_data", 32'(mem_wr_data), 32'(mon_e.d));
                end
            end
            if (mem_rd_en) rd_seen++;
            prev_strobe = mem_wr_en | mem_rd_en;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            master_valid = 1'b0;
            wr_bus       = 1'($urandom);
            tick();
        end
        master_valid = 1'b1;
        wr_bus       = b;
        @(negedge clk);
        check("slave_ready", 32'(slave_ready), 1);
        tick();
        master_valid = 1'b0;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic last_mode, input int gap);
        for (int i = 15; i >= 0; i--) begin
            mode = (i == 0) ? last_mode : 1'($urandom);
            send_bit(a[i], gap);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap);
        wr_q.push_back('{a: a[ADDR_W-1:0], d: d});
        mem_model[a[ADDR_W-1:0]] = d;
        select = 1'b1;
        send_addr(a, 1'b1, gap);
        for (int i = 7; i >= 0; i--) begin
            mem_rd_valid = 1'($urandom);
            send_bit(d[i], gap);
        end
        mem_rd_valid = 1'b0;
        @(negedge clk);
        check("wr_en", 32'(mem_wr_en), 1);
        check("wr_addr", 32'(mem_addr), 32'(a[ADDR_W-1:0]));
        check("wr_data", 32'(mem_wr_data), 32'(d));
        tick();
        @(negedge clk);
        check("wr_en_single", 32'(mem_wr_en), 0);
        check("wr_idle_rdy", 32'(slave_ready), 1);
        select = 1'b0;
        mode   = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [15:0] a, input int lat, input int stall,
                           input bit fixed_stall, input int gap, input bit drop_sel);
        logic [7:0] exp_d;
        int         n;
        exp_d = mem_model[a[ADDR_W-1:0]];
        rd_expected++;
        select = 1'b1;
        send_addr(a, 1'b0, gap);
        if (drop_sel) select = 1'b0;
        @(negedge clk);
        check("rd_en", 32'(mem_rd_en), 1);
        check("rd_addr", 32'(mem_addr), 32'(a[ADDR_W-1:0]));
        for (int i = 1; i <= lat; i++) begin
            tick();
            if (i == lat) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = exp_d;
            end else begin
                mem_rd_data  = 8'($urandom);
            end
            @(negedge clk);
            check("split_wait", 32'(split), 32'((i - 1) >= SPLIT_CYCLES));
            check("wait_no_vld", 32'(slave_valid), 0);
        end
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'($urandom);
        for (int b = 7; b >= 0; b--) begin
            n = fixed_stall ? stall : $urandom_range(stall, 0);
            master_ready = 1'b0;
            for (int s = 0; s < n; s++) begin
                @(negedge clk);
                check("rd_hold_bit", 32'(rd_bus), 32'(exp_d[b]));
                check("rd_hold_vld", 32'(slave_valid), 1);
                tick();
            end
            master_ready = 1'b1;
            @(negedge clk);
            check("rd_bit", 32'(rd_bus), 32'(exp_d[b]));
            check("rd_vld", 32'(slave_valid), 1);
            check("rd_split_clr", 32'(split), 0);
            if (b == 0) check("rd_addr_held", 32'(mem_addr), 32'(a[ADDR_W-1:0]));
            tick();
        end
        master_ready = 1'b0;
        @(negedge clk);
        check("rd_end_vld", 32'(slave_valid), 0);
        select = 1'b0;
        tick();
    endtask

    task automatic do_abort(input int nbits, input int gap);
        select = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mode = (i == 15) ? 1'b1 : 1'($urandom);
            send_bit(1'($urandom), gap);
        end
        select = 1'b0;
        @(negedge clk);
        check("abort_rdy", 32'(slave_ready), 0);
        tick();
        mode = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(slave_ready), 0);
        check({tag, "_valid"}, 32'(slave_valid), 0);
        check({tag, "_rd_bus"}, 32'(rd_bus), 0);
        check({tag, "_split"}, 32'(split), 0);
        check({tag, "_wr_en"}, 32'(mem_wr_en), 0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wr_data), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    int          kind;
    logic [15:0] r_addr;
    logic [7:0]  r_data;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = 8'($urandom);

        tick();
        tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("post_reset");
        tick();

        do_write(16'h1234, 8'hA5, 0);

        mem_model[12'h0C1] = 8'h3C;
        do_read(16'h00C1, 2, 0, 1'b1, 0, 1'b0);

        do_read(16'($urandom), 20, 5, 1'b1, 0, 1'b1);

        do_abort(7, 0);
        do_write(16'h0001, 8'hFF, 0);

        do_write(16'($urandom), 8'h5A, 1);

        // Reset while a slow read is parked in RD_WAIT with split raised.
        rd_expected++;
        select = 1'b1;
        send_addr(16'h00C1, 1'b0, 0);
        select = 1'b0;
        for (int i = 0; i < SPLIT_CYCLES + 2; i++) tick();
        @(negedge clk);
        check("pre_reset_split", 32'(split), 1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        rstn = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'hC3;
        tick();
        mem_rd_valid = 1'b0;
        @(negedge clk);
        check("stray_rd_valid_vld", 32'(slave_valid), 0);
        check("stray_rd_valid_split", 32'(split), 0);
        tick();

        for (int t = 0; t < 40; t++) begin
            kind   = $urandom_range(2, 0);
            r_addr = 16'($urandom);
            r_data = 8'($urandom);
            case (kind)
                0:       do_write(r_addr, r_data, $urandom_range(1, 0));
                1:       do_read(r_addr, $urandom_range(20, 1), $urandom_range(3, 0), 1'b0,
                                 $urandom_range(1, 0), 1'($urandom));
                default: do_abort($urandom_range(23, 1), $urandom_range(1, 0));
            endcase
        end

        check("wr_pending", 32'(wr_q.size()), 0);
        check("rd_strobe_count", 32'(rd_seen), 32'(rd_expected));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
